// File: rtl/avg_decim_ctrl.sv
// Block averager/decimator: averages 2^L unsigned samples and hands each result over a valid/ready port.
// Optional round-half-up before the shift when AVG_ROUND_EN is defined; the default build truncates.
module avg_decim_ctrl #(
  parameter int N        = 16,
  parameter int MAX_LOG2 = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [3:0]   log2_len,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_ovr
);

  localparam int AW = N + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t         state, state_next;
  logic [3:0]     len_l;
  logic [3:0]     len_clamped;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  sum_final;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_last;
  logic [N-1:0]   avg;
  logic           start;
  logic           accept;
  logic           last;
  logic           load;
  logic           drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = ACCUM;
      ACCUM:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state == ACCUM);
  assign start       = (state == IDLE) && enable;
  assign accept      = (state == ACCUM) && enable && in_valid;
  assign len_clamped = ({28'd0, log2_len} > 32'(MAX_LOG2)) ? 4'(MAX_LOG2) : log2_len;
  assign cnt_last    = CW'((32'd1 << len_l) - 32'd1);
  assign last        = accept && (cnt == cnt_last);
  assign sum         = acc + AW'(in_data);

`ifdef AVG_ROUND_EN
  // Half an LSB of the result, so the shift below rounds half up instead of truncating.
  logic [AW-1:0] bias;
  assign bias      = (len_l == 4'd0) ? '0 : (AW'(1) << (len_l - 4'd1));
  assign sum_final = sum + bias;
`else
  assign sum_final = sum;
`endif

  assign avg = N'(sum_final >> len_l);

  // Leaving ACCUM discards the partial block; the final sample restarts the next block gap-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_l <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      len_l <= len_clamped;
      acc   <= '0;
      cnt   <= '0;
    end else if ((state == ACCUM) && !enable) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign load = last && (!out_valid || out_ready);
  assign drop = last && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= avg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule
